// File: rtl/hybrid_core_pipe.sv
`default_nettype none
// ============================================================================
// hybrid_core_pipe : 3-stage 8-point WHT / Haar / bypass transform pipeline
// Rev 1.0
// ============================================================================
module hybrid_core_pipe #(
  parameter int W     = 12,
  parameter int CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [1:0]           t_select,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*W-1:0]       I,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [8*(W+3)-1:0]   O,
  output logic [1:0]           out_mode,
  output logic [CNT_W-1:0]     frame_cnt
);

  localparam int         WO        = W + 3;
  localparam logic [1:0] MODE_WHT  = 2'b01;
  localparam logic [1:0] MODE_HAAR = 2'b10;

  typedef logic signed [WO-1:0] samp_t;

  samp_t            x_w  [8];
  samp_t            s1_d [8];
  samp_t            s1_q [8];
  samp_t            s2_d [8];
  samp_t            s2_q [8];
  samp_t            s3_d [8];
  samp_t            s3_q [8];
  logic             s1_vld_q, s2_vld_q, s3_vld_q;
  logic [1:0]       s1_mode_q, s2_mode_q, s3_mode_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             stall;

  // Sign-extend each input sample to the full datapath width; drive O from S3.
  for (genvar n = 0; n < 8; n++) begin : g_lanes
    assign x_w[n]          = {{3{I[n*W+W-1]}}, I[n*W +: W]};
    assign O[n*WO +: WO]   = s3_q[n];
  end

  assign stall     = s3_vld_q && !out_ready;
  assign in_ready  = !stall;
  assign out_valid = s3_vld_q;
  assign out_mode  = s3_mode_q;
  assign frame_cnt = frame_cnt_q;

  // S1: WHT stride-4 butterflies, or Haar pair sums (lanes 0-3) / diffs (4-7).
  always_comb begin
    for (int k = 0; k < 8; k++) s1_d[k] = x_w[k];
    case (t_select)
      MODE_WHT: begin
        for (int n = 0; n < 4; n++) begin
          s1_d[n]   = x_w[n] + x_w[n+4];
          s1_d[n+4] = x_w[n] - x_w[n+4];
        end
      end
      MODE_HAAR: begin
        for (int m = 0; m < 4; m++) begin
          s1_d[m]   = x_w[2*m] + x_w[2*m+1];
          s1_d[m+4] = x_w[2*m] - x_w[2*m+1];
        end
      end
      default: ;
    endcase
  end

  // S2: WHT stride-2, or Haar second level on the sums (d lanes pass through).
  always_comb begin
    for (int k = 0; k < 8; k++) s2_d[k] = s1_q[k];
    case (s1_mode_q)
      MODE_WHT: begin
        for (int b = 0; b < 2; b++) begin
          for (int j = 0; j < 2; j++) begin
            s2_d[4*b+j]   = s1_q[4*b+j] + s1_q[4*b+j+2];
            s2_d[4*b+j+2] = s1_q[4*b+j] - s1_q[4*b+j+2];
          end
        end
      end
      MODE_HAAR: begin
        s2_d[0] = s1_q[0] + s1_q[1];
        s2_d[1] = s1_q[2] + s1_q[3];
        s2_d[2] = s1_q[0] - s1_q[1];
        s2_d[3] = s1_q[2] - s1_q[3];
      end
      default: ;
    endcase
  end

  // S3: WHT stride-1, or final Haar level landing a,b in lanes 0,1.
  always_comb begin
    for (int k = 0; k < 8; k++) s3_d[k] = s2_q[k];
    case (s2_mode_q)
      MODE_WHT: begin
        for (int p = 0; p < 4; p++) begin
          s3_d[2*p]   = s2_q[2*p] + s2_q[2*p+1];
          s3_d[2*p+1] = s2_q[2*p] - s2_q[2*p+1];
        end
      end
      MODE_HAAR: begin
        s3_d[0] = s2_q[0] + s2_q[1];
        s3_d[1] = s2_q[0] - s2_q[1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s3_vld_q    <= 1'b0;
      s1_mode_q   <= 2'b00;
      s2_mode_q   <= 2'b00;
      s3_mode_q   <= 2'b00;
      frame_cnt_q <= '0;
      for (int k = 0; k < 8; k++) begin
        s1_q[k] <= '0;
        s2_q[k] <= '0;
        s3_q[k] <= '0;
      end
    end else begin
      if (!stall) begin
        s1_vld_q  <= in_valid;
        s1_mode_q <= t_select;
        s2_vld_q  <= s1_vld_q;
        s2_mode_q <= s1_mode_q;
        s3_vld_q  <= s2_vld_q;
        s3_mode_q <= s2_mode_q;
        s1_q      <= s1_d;
        s2_q      <= s2_d;
        s3_q      <= s3_d;
      end
      if (s3_vld_q && out_ready) begin
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
